// File: rtl/max30003_spi_target.sv
// MAX30003-style SPI responder: oversampled mode-0 SPI, small register
// set, and an ECG sample FIFO streamed in from the fabric side.
module max30003_spi_target #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [23:0] INFO_VALUE   = 24'h500000,
  parameter logic [23:0] CNFG_GEN_RST = 24'h080004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [17:0] ecg_in,
  input  logic        ecg_in_valid,
  output logic [23:0] cnfg_gen,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic [23:0] wr_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  localparam logic [6:0] A_STATUS = 7'h01;
  localparam logic [6:0] A_SW_RST = 7'h08;
  localparam logic [6:0] A_FRST   = 7'h0A;
  localparam logic [6:0] A_INFO   = 7'h0F;
  localparam logic [6:0] A_CNFG   = 7'h10;
  localparam logic [6:0] A_FIFO   = 7'h21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RDATA,
    S_WDATA,
    S_DONE
  } state_t;

  logic [2:0]  sclk_sync_q;
  logic [2:0]  cs_sync_q;
  logic [1:0]  mosi_sync_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [22:0] shift_q;
  logic [6:0]  addr_q;
  logic [23:0] rd_q;
  logic        miso_q;

  logic [23:0] cnfg_q;
  logic        wr_strobe_q;
  logic [6:0]  wr_addr_q;
  logic [23:0] wr_data_q;

  logic [17:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q;

  logic        sclk_rise, sclk_fall;
  logic        cs_fall, cs_high;
  logic        mosi_bit;
  logic [7:0]  cmd_word;
  logic [23:0] data_word;
  logic        cmd_done, wr_commit, rd_shift;
  logic [23:0] rd_word;
  logic        fifo_empty, fifo_full;
  logic [17:0] fifo_head;
  logic        pop, push, drop, flush, ovf_clr;

  // Sync chain resets low so a CS already low at reset release never
  // looks like a falling edge; a frame starts only after CS was high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high   = cs_sync_q[1];
  assign mosi_bit  = mosi_sync_q[1];

  assign cmd_word  = {shift_q[6:0], mosi_bit};
  assign data_word = {shift_q, mosi_bit};

  // Frame sequencing: next state, bit counter and one-cycle controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_done  = 1'b0;
    wr_commit = 1'b0;
    rd_shift  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cs_fall) state_d = S_CMD;
      end
      S_CMD: begin
        if (cs_high) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          if (cnt_q == 5'd7) begin
            cmd_done = 1'b1;
            cnt_d    = '0;
            state_d  = cmd_word[0] ? S_RDATA : S_WDATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_RDATA: begin
        if (cs_high) begin
          state_d = S_IDLE;
        end else begin
          rd_shift = sclk_fall;
          if (sclk_rise) begin
            if (cnt_q == 5'd23) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      S_WDATA: begin
        if (cs_high) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          if (cnt_q == 5'd23) begin
            wr_commit = 1'b1;
            cnt_d     = '0;
            state_d   = S_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        if (cs_high) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FULL_CNT);
  assign fifo_head  = mem_q[rptr_q];

  // Read word captured at command exit from the decoded address.
  always_comb begin
    rd_word = 24'h000000;
    unique case (1'b1)
      cmd_word[7:1] == A_STATUS: rd_word = {~fifo_empty, ovf_q, 22'b0};
      cmd_word[7:1] == A_INFO:   rd_word = INFO_VALUE;
      cmd_word[7:1] == A_CNFG:   rd_word = cnfg_q;
      cmd_word[7:1] == A_FIFO: begin
        if (fifo_empty) rd_word = {18'b0, 3'b110, 3'b000};
        else rd_word = {fifo_head, {3{ovf_q}}, 3'b000};
      end
      default: rd_word = 24'h000000;
    endcase
  end

  assign pop   = cmd_done & cmd_word[0] & (cmd_word[7:1] == A_FIFO)
               & ~fifo_empty;
  assign flush = wr_commit
               & (((addr_q == A_SW_RST) & (data_word == 24'h0))
                  | (addr_q == A_FRST));
  assign push  = ecg_in_valid & (~fifo_full | pop) & ~flush;
  assign drop  = ecg_in_valid & fifo_full & ~pop;
  assign ovf_clr = pop | (wr_commit & (addr_q == A_FRST));

  // FSM state, bit shifting and the MISO output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sclk_rise && (state_q == S_CMD || state_q == S_WDATA))
        shift_q <= {shift_q[21:0], mosi_bit};
      if (cmd_done) addr_q <= cmd_word[7:1];
      if (cmd_done) rd_q <= rd_word;
      else if (rd_shift) rd_q <= {rd_q[22:0], 1'b0};
      if (rd_shift) miso_q <= rd_q[23];
      else if (state_q != S_RDATA) miso_q <= 1'b0;
    end
  end

  // Write commit: strobe, captured address/data and CNFG_GEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnfg_q      <= CNFG_GEN_RST;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_strobe_q <= wr_commit;
      if (wr_commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= data_word;
        if (addr_q == A_CNFG)
          cnfg_q <= data_word;
        else if (addr_q == A_SW_RST && data_word == 24'h0)
          cnfg_q <= CNFG_GEN_RST;
      end
    end
  end

  // FIFO pointers, occupancy and overflow flag; flush beats push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (ovf_clr) ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fcnt_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop) rptr_q <= rptr_q + 1'b1;
        if (push && !pop) fcnt_q <= fcnt_q + 1'b1;
        else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ecg_in;
  end

  assign spi_miso  = miso_q;
  assign cnfg_gen  = cnfg_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_max30003_spi_target.sv
// Bench for max30003_spi_target: directed vector table, reset corner
// cases, then random traffic against a queue-based reference model.
module tb_max30003_spi_target;

  localparam int HALF  = 6;
  localparam int DEPTH = 8;
  localparam logic [23:0] RSTV = 24'h080004;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_PUSH = 2;
  localparam int OP_ABORT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        spi_miso;
  logic [17:0] ecg_in = '0;
  logic        ecg_in_valid = 1'b0;
  logic [23:0] cnfg_gen;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [23:0] wr_data;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;

  typedef struct {
    int          op;
    logic [6:0]  addr;
    logic [23:0] data;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  logic [17:0] m_q[$];
  logic        m_ovf;
  logic [23:0] m_cfg;

  max30003_spi_target #(
    .FIFO_DEPTH(DEPTH),
    .INFO_VALUE(24'h500000),
    .CNFG_GEN_RST(RSTV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(sclk),
    .spi_cs(cs),
    .spi_mosi(mosi),
    .spi_miso(spi_miso),
    .ecg_in(ecg_in),
    .ecg_in_valid(ecg_in_valid),
    .cnfg_gen(cnfg_gen),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe) strobe_cnt <= strobe_cnt + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, inout logic [31:0] sh);
    mosi = b;
    clk_n(HALF);
    sh = {sh[30:0], spi_miso};
    sclk = 1'b1;
    clk_n(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [6:0] a, input logic rw,
                           input logic [23:0] d, input int nbits,
                           output logic [23:0] rd);
    logic [31:0] f;
    logic [31:0] sh;
    f = {a, rw, d};
    sh = '0;
    @(negedge clk);
    cs = 1'b0;
    clk_n(4);
    for (int i = 0; i < nbits; i++) send_bit(f[31-i], sh);
    clk_n(HALF);
    cs = 1'b1;
    mosi = 1'b0;
    clk_n(8);
    rd = sh[23:0];
  endtask

  task automatic push(input logic [17:0] s);
    @(negedge clk);
    ecg_in = s;
    ecg_in_valid = 1'b1;
    @(negedge clk);
    ecg_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clk_n(3);
    rst = 1'b0;
    clk_n(4);
  endtask

  task automatic m_push(input logic [17:0] s);
    if (m_q.size() < DEPTH) m_q.push_back(s);
    else m_ovf = 1'b1;
  endtask

  task automatic m_read(input logic [6:0] a, output logic [23:0] w);
    logic [17:0] s;
    w = 24'h0;
    if (a == 7'h01) w = {m_q.size() != 0, m_ovf, 22'b0};
    else if (a == 7'h0F) w = 24'h500000;
    else if (a == 7'h10) w = m_cfg;
    else if (a == 7'h21) begin
      if (m_q.size() == 0) w = 24'h000030;
      else begin
        s = m_q.pop_front();
        w = {s, m_ovf ? 3'b111 : 3'b000, 3'b000};
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic m_write(input logic [6:0] a, input logic [23:0] d);
    if (a == 7'h08 && d == 24'h0) begin
      m_cfg = RSTV;
      m_q.delete();
    end else if (a == 7'h0A) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (a == 7'h10) begin
      m_cfg = d;
    end
  endtask

  task automatic run_write(input string nm, input logic [6:0] a,
                           input logic [23:0] d, input logic [23:0] ecfg);
    int s0;
    logic [23:0] rd;
    s0 = strobe_cnt;
    spi_frame(a, 1'b0, d, 32, rd);
    chk({nm, "_strobes"}, strobe_cnt - s0, 1);
    chk({nm, "_addr"}, {25'b0, wr_addr}, {25'b0, a});
    chk({nm, "_data"}, {8'b0, wr_data}, {8'b0, d});
    chk({nm, "_cnfg"}, {8'b0, cnfg_gen}, {8'b0, ecfg});
  endtask

  initial begin
    logic [23:0] rd;
    logic [23:0] ew;
    logic [31:0] sh;
    logic [31:0] f;
    logic [6:0]  a;
    logic [23:0] d;
    int s0;
    int r;

    tbl.push_back('{OP_RD, 7'h0F, 24'h0, 24'h500000});
    tbl.push_back('{OP_RD, 7'h10, 24'h0, 24'h080004});
    tbl.push_back('{OP_WR, 7'h10, 24'h081007, 24'h081007});
    tbl.push_back('{OP_RD, 7'h10, 24'h0, 24'h081007});
    tbl.push_back('{OP_PUSH, 7'h0, 24'h000001, 24'h0});
    tbl.push_back('{OP_PUSH, 7'h0, 24'h03FFFF, 24'h0});
    tbl.push_back('{OP_RD, 7'h21, 24'h0, 24'h000040});
    tbl.push_back('{OP_RD, 7'h21, 24'h0, 24'hFFFFC0});
    tbl.push_back('{OP_RD, 7'h21, 24'h0, 24'h000030});
    for (int i = 1; i <= 9; i++)
      tbl.push_back('{OP_PUSH, 7'h0, 24'(i), 24'h0});
    tbl.push_back('{OP_RD, 7'h01, 24'h0, 24'hC00000});
    tbl.push_back('{OP_RD, 7'h21, 24'h0, 24'h000078});
    tbl.push_back('{OP_RD, 7'h01, 24'h0, 24'h800000});
    tbl.push_back('{OP_ABORT, 7'h10, 24'h123456, 24'h081007});
    tbl.push_back('{OP_WR, 7'h10, 24'h0ABCDE, 24'h0ABCDE});
    tbl.push_back('{OP_RD, 7'h10, 24'h0, 24'h0ABCDE});
    tbl.push_back('{OP_PUSH, 7'h0, 24'h000AAA, 24'h0});
    tbl.push_back('{OP_RD, 7'h01, 24'h0, 24'h800000});
    tbl.push_back('{OP_WR, 7'h08, 24'h000000, 24'h080004});
    tbl.push_back('{OP_RD, 7'h01, 24'h0, 24'h000000});
    tbl.push_back('{OP_RD, 7'h10, 24'h0, 24'h080004});
    tbl.push_back('{OP_WR, 7'h0A, 24'h000000, 24'h080004});
    tbl.push_back('{OP_WR, 7'h33, 24'h5A5A5A, 24'h080004});
    tbl.push_back('{OP_RD, 7'h33, 24'h0, 24'h000000});

    do_reset();
    chk("rst_miso", {31'b0, spi_miso}, 0);
    chk("rst_cnfg", {8'b0, cnfg_gen}, {8'b0, RSTV});
    chk("rst_strobe", {31'b0, wr_strobe}, 0);
    chk("rst_waddr", {25'b0, wr_addr}, 0);
    chk("rst_wdata", {8'b0, wr_data}, 0);

    foreach (tbl[k]) begin
      case (tbl[k].op)
        OP_RD: begin
          spi_frame(tbl[k].addr, 1'b1, 24'h0, 32, rd);
          chk($sformatf("vec%0d_rd%h", k, tbl[k].addr),
              {8'b0, rd}, {8'b0, tbl[k].exp});
        end
        OP_WR: run_write($sformatf("vec%0d_wr%h", k, tbl[k].addr),
                         tbl[k].addr, tbl[k].data, tbl[k].exp);
        OP_PUSH: push(tbl[k].data[17:0]);
        default: begin
          s0 = strobe_cnt;
          spi_frame(tbl[k].addr, 1'b0, tbl[k].data, 20, rd);
          chk($sformatf("vec%0d_abort_strobes", k), strobe_cnt - s0, 0);
          chk($sformatf("vec%0d_abort_cnfg", k),
              {8'b0, cnfg_gen}, {8'b0, tbl[k].exp});
        end
      endcase
    end

    // Reset arrives mid-frame with CS held low; rest of frame is ignored.
    s0 = strobe_cnt;
    f = {7'h10, 1'b0, 24'h00BEEF};
    sh = '0;
    @(negedge clk);
    cs = 1'b0;
    clk_n(4);
    for (int i = 0; i < 10; i++) send_bit(f[31-i], sh);
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    for (int i = 10; i < 32; i++) send_bit(f[31-i], sh);
    clk_n(HALF);
    cs = 1'b1;
    clk_n(8);
    chk("midrst_strobes", strobe_cnt - s0, 0);
    chk("midrst_cnfg", {8'b0, cnfg_gen}, {8'b0, RSTV});
    chk("midrst_miso", {31'b0, spi_miso}, 0);
    run_write("after_midrst", 7'h10, 24'h012345, 24'h012345);

    do_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cfg = RSTV;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 10);
      if (r <= 3) begin
        for (int j = 0; j < $urandom_range(1, 4); j++) begin
          d = 24'($urandom_range(0, 18'h3FFFF));
          push(d[17:0]);
          m_push(d[17:0]);
        end
      end else if (r <= 7) begin
        case ($urandom_range(0, 5))
          0: a = 7'h01;
          1: a = 7'h0F;
          2: a = 7'h10;
          3, 4: a = 7'h21;
          default: a = 7'($urandom);
        endcase
        m_read(a, ew);
        spi_frame(a, 1'b1, 24'h0, 32, rd);
        chk($sformatf("rnd%0d_rd%h", it, a), {8'b0, rd}, {8'b0, ew});
      end else if (r <= 9) begin
        case ($urandom_range(0, 3))
          0: a = 7'h10;
          1: a = 7'h0A;
          2: a = 7'h08;
          default: a = 7'($urandom);
        endcase
        d = 24'($urandom);
        if (a == 7'h08 && $urandom_range(0, 1) == 1) d = 24'h0;
        m_write(a, d);
        run_write($sformatf("rnd%0d_wr%h", it, a), a, d, m_cfg);
      end else begin
        s0 = strobe_cnt;
        a = 7'h10;
        d = 24'($urandom);
        spi_frame(a, 1'b0, d, $urandom_range(9, 31), rd);
        chk($sformatf("rnd%0d_abort_strobes", it), strobe_cnt - s0, 0);
        chk($sformatf("rnd%0d_abort_cnfg", it),
            {8'b0, cnfg_gen}, {8'b0, m_cfg});
      end
    end
    m_read(7'h01, ew);
    spi_frame(7'h01, 1'b1, 24'h0, 32, rd);
    chk("final_status", {8'b0, rd}, {8'b0, ew});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
